// File: rtl/wb_init_pkg.sv
// Shared types and default widths for the Wishbone single-transfer initiator.
package wb_init_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/wb_init_timeout.sv
// Saturating bus-phase cycle counter; expired flags the last permitted wait cycle.
module wb_init_timeout #(
    parameter int TIMEOUT = 255,
    parameter int TOW     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TOW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TOW'(TIMEOUT - 1);
    localparam logic [TOW-1:0] MAX   = '1;

    logic [TOW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + TOW'(1);
        end
    end

    // A zero TIMEOUT means wait forever.
    assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/wb_host_initiator.sv
// Wishbone classic initiator: one bus cycle per command, response on a valid/ready channel.
module wb_host_initiator
    import wb_init_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TOW     = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i
);

    state_t state_q, state_d;
    logic   accept;
    logic   terminate;
    logic   term_err;
    logic   rsp_take;
    logic   expired;

    assign cmd_ready_o = (state_q == IDLE) && !wb_rst_i;

    wb_init_timeout #(
        .TIMEOUT (TIMEOUT),
        .TOW     (TOW)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (accept),
        .enable  (state_q == BUS),
        .expired (expired)
    );

    // Termination priority is err, then ack, then timeout.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        terminate = 1'b0;
        term_err  = 1'b0;
        rsp_take  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wbm_err_i) begin
                    terminate = 1'b1;
                    term_err  = 1'b1;
                    state_d   = RESP;
                end else if (wbm_ack_i) begin
                    terminate = 1'b1;
                    state_d   = RESP;
                end else if (expired) begin
                    terminate = 1'b1;
                    term_err  = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_take = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= cmd_we_i;
                wbm_sel_o <= cmd_sel_i;
                wbm_adr_o <= cmd_adr_i;
                wbm_dat_o <= cmd_dat_i;
            end
            // Address/data stay put after termination; only cyc/stb qualify them.
            if (terminate) begin
                wbm_cyc_o   <= 1'b0;
                wbm_stb_o   <= 1'b0;
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= term_err;
                rsp_dat_o   <= (!term_err && !wbm_we_o) ? wbm_dat_i : '0;
            end
            if (rsp_take) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_host_initiator.sv
// Directed bench for wb_host_initiator: main instance with TIMEOUT=8, second with timeout disabled.
module tb_wb_host_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack;
    logic        wbm_err;

    logic        z_cmd_valid;
    logic        z_cmd_ready;
    logic        z_rsp_valid;
    logic        z_rsp_ready;
    logic [31:0] z_rsp_dat;
    logic        z_rsp_err;
    logic        z_cyc;
    logic        z_stb;
    logic        z_we;
    logic [3:0]  z_sel;
    logic [31:0] z_adr;
    logic [31:0] z_dat_o;
    logic [31:0] z_dat_i;
    logic        z_ack;
    logic        z_err;

    int checks = 0;
    int errors = 0;
    int cycles;

    always #5 clk = ~clk;

    wb_host_initiator #(.AW(32), .DW(32), .TIMEOUT(8), .TOW(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_sel_i   (cmd_sel),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack),
        .wbm_err_i   (wbm_err)
    );

    wb_host_initiator #(.AW(32), .DW(32), .TIMEOUT(0), .TOW(8)) dut_notimeout (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (z_cmd_valid),
        .cmd_ready_o (z_cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_sel_i   (cmd_sel),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .rsp_valid_o (z_rsp_valid),
        .rsp_ready_i (z_rsp_ready),
        .rsp_dat_o   (z_rsp_dat),
        .rsp_err_o   (z_rsp_err),
        .wbm_cyc_o   (z_cyc),
        .wbm_stb_o   (z_stb),
        .wbm_we_o    (z_we),
        .wbm_sel_o   (z_sel),
        .wbm_adr_o   (z_adr),
        .wbm_dat_o   (z_dat_o),
        .wbm_dat_i   (z_dat_i),
        .wbm_ack_i   (z_ack),
        .wbm_err_i   (z_err)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one command for a single edge, then plays a slave that acks/errs on the given stb cycle.
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int ack_at, input int err_at,
                                 input logic [31:0] rdata, output int n);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        wbm_dat_i = rdata;
        n = 0;
        while (wbm_cyc === 1'b1 && n < 40) begin
            n++;
            wbm_ack = (n == ack_at);
            wbm_err = (n == err_at);
            step();
        end
        wbm_ack = 1'b0;
        wbm_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_we      = 1'b0;
        cmd_sel     = 4'h0;
        cmd_adr     = 32'h0;
        cmd_dat     = 32'h0;
        rsp_ready   = 1'b1;
        wbm_dat_i   = 32'h0;
        wbm_ack     = 1'b0;
        wbm_err     = 1'b0;
        z_cmd_valid = 1'b0;
        z_rsp_ready = 1'b1;
        z_dat_i     = 32'h0;
        z_ack       = 1'b0;
        z_err       = 1'b0;

        step();
        step();
        checkOutput("reset_cyc",       32'(wbm_cyc),   32'h0);
        checkOutput("reset_stb",       32'(wbm_stb),   32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rsp_dat",   rsp_dat,        32'h0);
        checkOutput("reset_adr",       wbm_adr,        32'h0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'h0);
        rst = 1'b0;
        step();
        checkOutput("idle_cmd_ready",  32'(cmd_ready), 32'h1);

        $display("[TB] zero-wait write");
        applyStimulus(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'h0, cycles);
        checkOutput("wr_cyc_cycles", 32'(cycles),    32'd1);
        checkOutput("wr_adr",        wbm_adr,        32'h3000_0004);
        checkOutput("wr_dat",        wbm_dat_o,      32'hDEAD_BEEF);
        checkOutput("wr_sel",        32'(wbm_sel),   32'hF);
        checkOutput("wr_we",         32'(wbm_we),    32'h1);
        checkOutput("wr_stb_low",    32'(wbm_stb),   32'h0);
        checkOutput("wr_rsp_valid",  32'(rsp_valid), 32'h1);
        checkOutput("wr_rsp_err",    32'(rsp_err),   32'h0);
        checkOutput("wr_rsp_dat",    rsp_dat,        32'h0);
        step();
        checkOutput("wr_rsp_taken",  32'(rsp_valid), 32'h0);
        checkOutput("wr_ready_back", 32'(cmd_ready), 32'h1);

        $display("[TB] read with 3 wait states");
        applyStimulus(1'b0, 32'h3000_0010, 32'h0, 4'hF, 4, 0, 32'h1234_5678, cycles);
        checkOutput("rd_cyc_cycles", 32'(cycles),    32'd4);
        checkOutput("rd_adr",        wbm_adr,        32'h3000_0010);
        checkOutput("rd_we",         32'(wbm_we),    32'h0);
        checkOutput("rd_rsp_valid",  32'(rsp_valid), 32'h1);
        checkOutput("rd_rsp_err",    32'(rsp_err),   32'h0);
        checkOutput("rd_rsp_dat",    rsp_dat,        32'h1234_5678);
        step();

        $display("[TB] timeout with silent slave");
        applyStimulus(1'b0, 32'h3000_0020, 32'h0, 4'h3, 0, 0, 32'hFFFF_FFFF, cycles);
        checkOutput("to_cyc_cycles", 32'(cycles),    32'd8);
        checkOutput("to_rsp_valid",  32'(rsp_valid), 32'h1);
        checkOutput("to_rsp_err",    32'(rsp_err),   32'h1);
        checkOutput("to_rsp_dat",    rsp_dat,        32'h0);
        step();

        $display("[TB] err and ack together");
        applyStimulus(1'b0, 32'h3000_0030, 32'h0, 4'hF, 2, 2, 32'hAAAA_5555, cycles);
        checkOutput("pri_cyc_cycles", 32'(cycles),    32'd2);
        checkOutput("pri_rsp_err",    32'(rsp_err),   32'h1);
        checkOutput("pri_rsp_dat",    rsp_dat,        32'h0);
        step();

        $display("[TB] stray ack/err in idle");
        wbm_ack = 1'b1;
        wbm_err = 1'b1;
        step();
        step();
        checkOutput("stray_cyc",       32'(wbm_cyc),   32'h0);
        checkOutput("stray_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("stray_cmd_ready", 32'(cmd_ready), 32'h1);
        wbm_ack = 1'b0;
        wbm_err = 1'b0;

        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 0, 32'h0BAD_F00D, cycles);
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_000C;
        cmd_sel   = 4'h1;
        cmd_valid = 1'b1;
        wbm_dat_i = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            checkOutput("bp_rsp_dat",   rsp_dat,        32'h0BAD_F00D);
            checkOutput("bp_rsp_err",   32'(rsp_err),   32'h0);
            checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'h0);
            checkOutput("bp_adr_held",  wbm_adr,        32'h3000_0008);
            step();
        end
        rsp_ready = 1'b1;
        step();
        checkOutput("bp_rsp_released", 32'(rsp_valid), 32'h0);
        checkOutput("bp_cmd_ready_up", 32'(cmd_ready), 32'h1);
        checkOutput("bp_cyc_idle",     32'(wbm_cyc),   32'h0);
        step();
        cmd_valid = 1'b0;
        checkOutput("bp2_cyc",     32'(wbm_cyc), 32'h1);
        checkOutput("bp2_adr",     wbm_adr,      32'h3000_000C);
        checkOutput("bp2_sel",     32'(wbm_sel), 32'h1);
        wbm_dat_i = 32'hCAFE_F00D;
        wbm_ack   = 1'b1;
        step();
        wbm_ack = 1'b0;
        checkOutput("bp2_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("bp2_rsp_dat",   rsp_dat,        32'hCAFE_F00D);
        step();

        $display("[TB] reset during wait states");
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0050;
        cmd_sel   = 4'hF;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        checkOutput("rst_pre_cyc", 32'(wbm_cyc), 32'h1);
        rst = 1'b1;
        step();
        checkOutput("rst_cyc",       32'(wbm_cyc),   32'h0);
        checkOutput("rst_stb",       32'(wbm_stb),   32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        step();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        checkOutput("rst_no_rsp",    32'(rsp_valid), 32'h0);
        applyStimulus(1'b0, 32'h3000_0060, 32'h0, 4'hF, 2, 0, 32'h55AA_33CC, cycles);
        checkOutput("post_rst_cycles", 32'(cycles),  32'd2);
        checkOutput("post_rst_dat",    rsp_dat,      32'h55AA_33CC);
        checkOutput("post_rst_err",    32'(rsp_err), 32'h0);
        step();

        $display("[TB] timeout disabled, ack after 300 cycles");
        cmd_we      = 1'b0;
        cmd_adr     = 32'h3000_0040;
        cmd_sel     = 4'hF;
        z_dat_i     = 32'h600D_F00D;
        z_cmd_valid = 1'b1;
        step();
        z_cmd_valid = 1'b0;
        cycles = 0;
        while (z_cyc === 1'b1 && cycles < 320) begin
            cycles++;
            z_ack = (cycles == 300);
            step();
        end
        z_ack = 1'b0;
        checkOutput("nto_cyc_cycles", 32'(cycles),      32'd300);
        checkOutput("nto_rsp_valid",  32'(z_rsp_valid), 32'h1);
        checkOutput("nto_rsp_err",    32'(z_rsp_err),   32'h0);
        checkOutput("nto_rsp_dat",    z_rsp_dat,        32'h600D_F00D);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
